// File: rtl/tla_win_sched.sv
// ---------------------------------------------------------------------------
// tla_win_sched
//
// Window scheduler in the Gc_clk125 domain. It shares the single
// capture/communication window between a capture requester and a
// communication requester with round-robin arbitration. It emits one-cycle
// open/close pulses for the downstream 125->200 MHz pulse crossing. It holds
// the granted window select, length and capture mode stable for the whole
// window. After every close pulse it forces an idle gap, so that successive
// pulses stay far enough apart for the crossing to resolve them.
//
// Parameters:
//   TOP0_0  width of the window-select field
//   LDD0_0  width of the window-length field (Gc_clk125 cycles)
//   GAP0_0  idle cycles forced after each close pulse (1..15)
//
// Ports:
//   Gc_clk125     in   system clock, 125 MHz
//   Gc_rst_n      in   asynchronous active-low reset
//   cap_req       in   capture requester wants a window (level)
//   cap_wdis      in   capture window select, sampled at grant
//   cap_plus      in   capture window length, sampled at grant
//   cap_ack       out  one-cycle grant to the capture requester
//   com_req       in   communication requester wants a window (level)
//   com_wdis      in   communication window select, sampled at grant
//   com_plus      in   communication window length, sampled at grant
//   com_ack       out  one-cycle grant to the communication requester
//   abort         in   terminate the running window early
//   Gc_com_open   out  one-cycle open pulse
//   Gc_com_close  out  one-cycle close pulse
//   Gc_cap_mode   out  high while a capture-owned window is active
//   Gc_wdis       out  latched window select of the active window
//   Gc_plus       out  latched window length of the active window
//   busy          out  high in any state other than IDLE
// ---------------------------------------------------------------------------
module tla_win_sched #(
    parameter int TOP0_0 = 3,
    parameter int LDD0_0 = 32,
    parameter int GAP0_0 = 4
) (
    input  logic              Gc_clk125,
    input  logic              Gc_rst_n,
    input  logic              cap_req,
    input  logic [TOP0_0-1:0] cap_wdis,
    input  logic [LDD0_0-1:0] cap_plus,
    output logic              cap_ack,
    input  logic              com_req,
    input  logic [TOP0_0-1:0] com_wdis,
    input  logic [LDD0_0-1:0] com_plus,
    output logic              com_ack,
    input  logic              abort,
    output logic              Gc_com_open,
    output logic              Gc_com_close,
    output logic              Gc_cap_mode,
    output logic [TOP0_0-1:0] Gc_wdis,
    output logic [LDD0_0-1:0] Gc_plus,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPEN,
        S_RUN,
        S_CLOSE,
        S_GAP
    } state_t;

    localparam logic [3:0]        GAP_LOAD = 4'(GAP0_0 - 1);
    localparam logic [LDD0_0-1:0] CNT_ONE  = LDD0_0'(1);

    state_t            state;
    logic [LDD0_0-1:0] win_cnt;
    logic [3:0]        gap_cnt;
    logic              last_cap;   // 1: last grant went to capture
    logic              grant_cap;
    logic [LDD0_0-1:0] open_load;

    // A zero length is treated as a one-cycle window, so the loaded count
    // is max(len,1)-1 and never underflows.
    function automatic logic [LDD0_0-1:0] win_load(input logic [LDD0_0-1:0] len);
        return (len == '0) ? '0 : len - CNT_ONE;
    endfunction

    // Capture wins when it is alone, or on a tie when com was granted last.
    assign grant_cap = cap_req && (!com_req || !last_cap);
    assign open_load = win_load(Gc_plus);

    always_ff @(posedge Gc_clk125 or negedge Gc_rst_n) begin
        if (!Gc_rst_n) begin
            state        <= S_IDLE;
            win_cnt      <= '0;
            gap_cnt      <= '0;
            last_cap     <= 1'b0;
            cap_ack      <= 1'b0;
            com_ack      <= 1'b0;
            Gc_com_open  <= 1'b0;
            Gc_com_close <= 1'b0;
            Gc_cap_mode  <= 1'b0;
            Gc_wdis      <= '0;
            Gc_plus      <= '0;
            busy         <= 1'b0;
        end else begin
            // Pulses default low; each is raised only on its entry edge.
            cap_ack      <= 1'b0;
            com_ack      <= 1'b0;
            Gc_com_open  <= 1'b0;
            Gc_com_close <= 1'b0;

            case (state)
                // Arbitration: latch the winner's fields on the grant edge.
                S_IDLE: begin
                    if (cap_req || com_req) begin
                        state       <= S_OPEN;
                        busy        <= 1'b1;
                        Gc_com_open <= 1'b1;
                        last_cap    <= grant_cap;
                        Gc_cap_mode <= grant_cap;
                        if (grant_cap) begin
                            cap_ack <= 1'b1;
                            Gc_wdis <= cap_wdis;
                            Gc_plus <= cap_plus;
                        end else begin
                            com_ack <= 1'b1;
                            Gc_wdis <= com_wdis;
                            Gc_plus <= com_plus;
                        end
                    end
                end

                // Open cycle: load the window counter.
                S_OPEN: begin
                    win_cnt <= open_load;
                    if (open_load == '0) begin
                        state        <= S_CLOSE;
                        Gc_com_close <= 1'b1;
                    end else begin
                        state <= S_RUN;
                    end
                end

                // Window running: the counter is always >= 1 here, so the
                // step that takes it to zero is the close edge. An abort that
                // coincides with expiry takes the same single transition.
                S_RUN: begin
                    if (abort || (win_cnt == CNT_ONE)) begin
                        state        <= S_CLOSE;
                        Gc_com_close <= 1'b1;
                        win_cnt      <= '0;
                    end else begin
                        win_cnt <= win_cnt - CNT_ONE;
                    end
                end

                // Close cycle: start the mandatory idle gap.
                S_CLOSE: begin
                    state       <= S_GAP;
                    gap_cnt     <= GAP_LOAD;
                    Gc_cap_mode <= 1'b0;
                end

                // Idle gap: window select and length stay latched.
                S_GAP: begin
                    if (gap_cnt == '0) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/tla_win_sched.md
# tla_win_sched

Window scheduler in the Gc_clk125 domain that shares the single capture/communication window resource between a capture requester and a communication requester. It arbitrates round-robin between them. It issues the one-cycle open and close pulses that feed the 125→200 MHz pulse-crossing stage, and it holds the granted window select, pulse count and capture mode stable for the duration of each window. A mandatory idle gap after every close guarantees that successive pulses stay far enough apart for the downstream pulse crossing to resolve.

## Interface
Parameters:
- TOP0_0, 3: width of the window-select field (wdis).
- LDD0_0, 32: width of the window length field (plus), in Gc_clk125 cycles.
- GAP0_0, 4: idle cycles forced after each close pulse; legal range 1–15.

Ports:
- Gc_clk125  in  1  system clock, 125 MHz.
- Gc_rst_n  in  1  reset, asynchronous, active-low.
- cap_req  in  1  capture requester wants a window (level).
- cap_wdis  in  TOP0_0  capture window select, sampled at grant.
- cap_plus  in  LDD0_0  capture window length, sampled at grant.
- cap_ack  out  1  one-cycle grant to the capture requester.
- com_req  in  1  communication requester wants a window (level).
- com_wdis  in  TOP0_0  communication window select, sampled at grant.
- com_plus  in  LDD0_0  communication window length, sampled at grant.
- com_ack  out  1  one-cycle grant to the communication requester.
- abort  in  1  terminate the current window early.
- Gc_com_open  out  1  one-cycle open pulse.
- Gc_com_close  out  1  one-cycle close pulse.
- Gc_cap_mode  out  1  high while a capture-owned window is active.
- Gc_wdis  out  TOP0_0  latched window select of the active window.
- Gc_plus  out  LDD0_0  latched window length of the active window.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, OPEN, RUN, CLOSE, GAP. All outputs are registered.
- IDLE: requests are sampled here.
  - If exactly one requester asserts req, that requester wins.
  - If both assert req, the requester not granted last time wins.
  - The last-grant pointer resets to "com", so capture wins the first tie.
  - On a win: go to OPEN; latch the winner's wdis/plus into Gc_wdis/Gc_plus; set Gc_cap_mode=1 if capture won, else 0.
- OPEN, one cycle:
  - Gc_com_open=1 and the winner's ack=1.
  - Load the down-counter with max(plus,1)-1; plus=0 is treated as 1.
  - Go to RUN if the loaded value is nonzero, otherwise go to CLOSE.
- RUN:
  - Decrement the counter each cycle.
  - When the counter reaches 0, go to CLOSE.
  - If abort=1, go to CLOSE on the next edge regardless of the count.
- CLOSE, one cycle: Gc_com_close=1. Go to GAP with the gap counter set to GAP0_0-1.
- GAP:
  - Gc_cap_mode drops to 0 on entry.
  - Count down; at 0, go to IDLE.
  - Gc_wdis and Gc_plus hold their last values until the next grant.
- Requests are sampled only in IDLE. A requester must drop req the cycle after its ack; if req is still high in IDLE, it is treated as a new request.
- abort is ignored in IDLE, OPEN, CLOSE and GAP.
- If abort arrives in the same cycle the counter expires, exactly one close pulse is produced.
- Reset (asynchronous, any state, including mid-window):
  - FSM goes to IDLE; all pulses, acks, busy and Gc_cap_mode go to 0.
  - Gc_wdis and Gc_plus go to 0; counters go to 0; pointer goes to "com".
  - No close pulse is emitted for a window cut by reset.

## Timing
- A request seen in IDLE at edge n produces open and ack high in cycle n+1.
- Gc_com_close is asserted exactly max(plus,1) cycles after Gc_com_open rises, unless aborted.
- An abort sampled high at edge m in RUN produces the close pulse in cycle m+1.
- busy rises with OPEN and falls on entry to IDLE, which is GAP0_0 cycles after the close pulse.
- Minimum spacing from one open pulse to the next is max(plus,1) + GAP0_0 + 2 cycles.
- Gc_cap_mode, Gc_wdis and Gc_plus are stable from the open pulse through the close pulse.

## Test plan
- Single capture window: cap_req with wdis=5, plus=10 → cap_ack and open in the same cycle; close 10 cycles later; Gc_cap_mode=1 from open through close; Gc_wdis=5, Gc_plus=10.
- Fairness: cap_req and com_req held high together across three windows → grants go cap, com, cap; open-to-open spacing equals plus+GAP0_0+2.
- Degenerate lengths: plus=0 and plus=1 → close pulse exactly 1 cycle after open in both cases; with all-ones plus, the counter runs to completion without wrap.
- Abort: abort at RUN cycle 3 of a plus=20 window → close in the next cycle; abort coinciding with expiry → a single close pulse; abort in GAP → no effect.
- Reset mid-window: drop Gc_rst_n during RUN → all outputs go to 0 immediately and no close pulse is emitted; after release, a com_req and cap_req tie is granted to capture.
